line_scan_sequencer: RTL and testbench

- Sequential front end for the 3-to-8 line decoder.
- Walks through a set of selected decoder lines, driving the decoder's Enable, A, B and C inputs and holding each line active for a programmable dwell time.
- Supports single-pass and continuous (wrap-around) scanning, with start/stop control.
- Sits directly upstream of the decoder; its registered outputs connect straight to the decoder's Enable/A/B/C.

---
 rtl/line_scan_pkg.sv | 16 +
 rtl/scan_next_index.sv | 36 +++
 rtl/line_scan_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_line_scan_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/line_scan_pkg.sv
// line_scan_pkg
// Shared definitions for the line scan sequencer: FSM state encoding,
// the number of decoder lines and the width of a line index.
// No ports.
package line_scan_pkg;

  localparam int NUM_LINES = 8;
  localparam int SEL_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_e;

endpackage

// File: rtl/scan_next_index.sv
// scan_next_index
// Combinational helper that searches a line mask relative to the current
// line index.
// Ports:
//   mask_i   [NUM_LINES-1:0] in   set of lines to be scanned
//   cur_i    [SEL_W-1:0]     in   index of the line currently shown
//   next_o   [SEL_W-1:0]     out  lowest set index strictly above cur_i
//   found_o                  out  1 when next_o is valid
//   lowest_o [SEL_W-1:0]     out  lowest set index (first line / wrap target)
module scan_next_index
  import line_scan_pkg::*;
(
  input  logic [NUM_LINES-1:0] mask_i,
  input  logic [SEL_W-1:0]     cur_i,
  output logic [SEL_W-1:0]     next_o,
  output logic                 found_o,
  output logic [SEL_W-1:0]     lowest_o
);

  // Walk from the top line down so that the last hit is the lowest one.
  always_comb begin
    next_o   = '0;
    found_o  = 1'b0;
    lowest_o = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        lowest_o = SEL_W'(i);
        if (i > int'(cur_i)) begin
          next_o  = SEL_W'(i);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/line_scan_sequencer.sv
// line_scan_sequencer
// Sequential front end for a 3-to-8 line decoder. Walks through the lines
// selected by a captured mask, holding each one enabled for DWELL cycles,
// in single-pass or continuous (wrap-around) mode.
// Optional build macro: LINE_SCAN_BLANKING_EN -- inserts one enable=0 BLANK
// cycle between consecutive lines (also at wrap), with the next index shown.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   begin a scan (sampled only in IDLE)
//   stop         in   abort a scan; wins over start
//   cont         in   continuous mode, captured with start
//   mask [7:0]   in   line select, captured with start
//   enable       out  decoder Enable
//   a, b, c      out  decoder index, a = MSB, c = LSB
//   busy         out  high while not IDLE
//   done         out  one-cycle pulse when a single-pass scan ends
//   dbg_state_o  out  current FSM state, for observation only
// Handshake: start/stop are level-sampled requests with no ready; start is
// accepted on a rising edge only when the FSM is IDLE and stop is low.
module line_scan_sequencer
  import line_scan_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cont,
  input  logic [NUM_LINES-1:0] mask,
  output logic                 enable,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 busy,
  output logic                 done,
  output state_e               dbg_state_o
);

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [NUM_LINES-1:0] mask_q, mask_d;
  logic                 cont_q, cont_d;
  logic                 enable_q, enable_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [NUM_LINES-1:0] mask_sel;
  logic [SEL_W-1:0]     nxt_idx, low_idx, next_line;
  logic                 nxt_found, dwell_last, start_go, advance;

  // In IDLE the first line comes from the mask being captured this edge.
  assign mask_sel   = (state_q == IDLE) ? mask : mask_q;
  assign dwell_last = (dwell_q == DWELL_W'(DWELL));
  assign start_go   = (state_q == IDLE) && start && !stop;
  assign advance    = nxt_found || cont_q;
  assign next_line  = nxt_found ? nxt_idx : low_idx;

  scan_next_index u_next (
    .mask_i   (mask_sel),
    .cur_i    (idx_q),
    .next_o   (nxt_idx),
    .found_o  (nxt_found),
    .lowest_o (low_idx)
  );

  // State register and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      mask_q   <= '0;
      cont_q   <= 1'b0;
      enable_q <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      mask_q   <= mask_d;
      cont_q   <= cont_d;
      enable_q <= enable_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_go && (mask != '0)) state_d = SCAN;
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (dwell_last) begin
          if (advance) begin
`ifdef LINE_SCAN_BLANKING_EN
            state_d = BLANK;
`else
            state_d = SCAN;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef LINE_SCAN_BLANKING_EN
      BLANK: begin
        state_d = stop ? IDLE : SCAN;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    dwell_d  = dwell_q;
    mask_d   = mask_q;
    cont_d   = cont_q;
    enable_d = enable_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (start_go) begin
          mask_d = mask;
          cont_d = cont;
          if (mask == '0) begin
            done_d = 1'b1;
          end else begin
            enable_d = 1'b1;
            idx_d    = low_idx;
            dwell_d  = DWELL_W'(1);
          end
        end
      end
      SCAN: begin
        if (stop) begin
          enable_d = 1'b0;
        end else if (dwell_last) begin
          if (advance) begin
            // Index moves only on a line boundary; counter restarts at 1.
            idx_d   = next_line;
            dwell_d = DWELL_W'(1);
`ifdef LINE_SCAN_BLANKING_EN
            enable_d = 1'b0;
`else
            enable_d = 1'b1;
`endif
          end else begin
            enable_d = 1'b0;
            done_d   = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
`ifdef LINE_SCAN_BLANKING_EN
      BLANK: begin
        // Index already points at the next line; counter already at 1.
        enable_d = !stop;
      end
`endif
      default: enable_d = 1'b0;
    endcase
  end

  assign enable      = enable_q;
  assign a           = idx_q[2];
  assign b           = idx_q[1];
  assign c           = idx_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_line_scan_sequencer.sv
// tb_line_scan_sequencer
// Directed bench for line_scan_sequencer. Each test pushes the expected
// per-cycle output vector {enable,a,b,c,busy,done} into a queue before
// driving stimulus; every cycle one entry is popped and compared.
module tb_line_scan_sequencer;
  import line_scan_pkg::*;

  localparam int W = 6;

  logic       clk = 1'b0;
  logic       reset, start, stop, cont;
  logic [7:0] mask;
  logic       enable, a, b, c, busy, done;
  state_e     dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  string        tag   = "init";

  line_scan_sequencer #(.DWELL(4), .DWELL_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .cont        (cont),
    .mask        (mask),
    .enable      (enable),
    .a           (a),
    .b           (b),
    .c           (c),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] vec(input logic en, input logic [2:0] idx,
                                       input logic bsy, input logic dn);
    return {en, idx, bsy, dn};
  endfunction

  // Scoreboard helpers
  task automatic push_line(input logic [2:0] idx, input int n);
    repeat (n) exp_q.push_back(vec(1'b1, idx, 1'b1, 1'b0));
  endtask

  task automatic push_gap(input logic [2:0] idx);
`ifdef LINE_SCAN_BLANKING_EN
    exp_q.push_back(vec(1'b0, idx, 1'b1, 1'b0));
`endif
  endtask

  task automatic push_done(input logic [2:0] idx);
    exp_q.push_back(vec(1'b0, idx, 1'b0, 1'b1));
    exp_q.push_back(vec(1'b0, idx, 1'b0, 1'b0));
  endtask

  // One clock; sample 1 time unit after the edge and compare if expected.
  task automatic step();
    logic [W-1:0] exp_v, got_v;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {enable, a, b, c, busy, done};
      n_vec++;
      assert (got_v === exp_v) else begin
        n_err++;
        $error("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, got_v, exp_v);
      end
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step();
  endtask

  task automatic pulse_start(input logic [7:0] m, input logic cn);
    mask  = m;
    cont  = cn;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; mask = 8'h00;

    // Reset state
    tag = "reset";
    step();
    exp_q.push_back(vec(1'b0, 3'd0, 1'b0, 1'b0));
    step();
    reset = 1'b0;
    exp_q.push_back(vec(1'b0, 3'd0, 1'b0, 1'b0));
    step();

    // Full mask, single pass
    tag = "mask_ff";
    for (int i = 0; i < 8; i++) begin
      if (i > 0) push_gap(3'(i));
      push_line(3'(i), 4);
    end
    push_done(3'd7);
    pulse_start(8'hFF, 1'b0);
    drain();

    // Sparse mask 0,2,7
    tag = "mask_85";
    push_line(3'd0, 4); push_gap(3'd2);
    push_line(3'd2, 4); push_gap(3'd7);
    push_line(3'd7, 4);
    push_done(3'd7);
    pulse_start(8'h85, 1'b0);
    drain();

    // Empty mask: immediate done, busy never rises, index held
    tag = "mask_00";
    push_done(3'd7);
    exp_q.push_back(vec(1'b0, 3'd7, 1'b0, 1'b0));
    pulse_start(8'h00, 1'b0);
    drain();

    // Two adjacent lines
    tag = "mask_03";
    push_line(3'd0, 4); push_gap(3'd1);
    push_line(3'd1, 4);
    push_done(3'd1);
    pulse_start(8'h03, 1'b0);
    drain();

    // Continuous 0,7 with stop in the 6th enabled cycle
    tag = "cont_81_stop";
    push_line(3'd0, 4); push_gap(3'd7);
    push_line(3'd7, 2);
    pulse_start(8'h81, 1'b1);
    drain();
    stop = 1'b1;
    exp_q.push_back(vec(1'b0, 3'd7, 1'b0, 1'b0));
    step();
    stop = 1'b0;
    exp_q.push_back(vec(1'b0, 3'd7, 1'b0, 1'b0));
    step();

    // stop wins over start in IDLE
    tag = "stop_over_start";
    mask = 8'hFF; start = 1'b1; stop = 1'b1;
    exp_q.push_back(vec(1'b0, 3'd7, 1'b0, 1'b0));
    step();
    start = 1'b0; stop = 1'b0;
    exp_q.push_back(vec(1'b0, 3'd7, 1'b0, 1'b0));
    step();

    // Single line, continuous: same line re-entered
    tag = "cont_single";
    push_line(3'd4, 4); push_gap(3'd4);
    push_line(3'd4, 4); push_gap(3'd4);
    push_line(3'd4, 2);
    pulse_start(8'h10, 1'b1);
    drain();
    stop = 1'b1;
    exp_q.push_back(vec(1'b0, 3'd4, 1'b0, 1'b0));
    step();
    stop = 1'b0;

    // Reset in the middle of line 3
    tag = "reset_mid";
    push_line(3'd0, 4); push_gap(3'd1);
    push_line(3'd1, 4); push_gap(3'd2);
    push_line(3'd2, 4); push_gap(3'd3);
    push_line(3'd3, 2);
    pulse_start(8'hFF, 1'b0);
    drain();
    reset = 1'b1;
    exp_q.push_back(vec(1'b0, 3'd0, 1'b0, 1'b0));
    step();
    reset = 1'b0;

    // Line 1 only; start and mask/cont changes mid-scan are ignored
    tag = "mask_02_ignore";
    push_line(3'd1, 4);
    push_done(3'd1);
    pulse_start(8'h02, 1'b0);
    mask = 8'hFF; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
